// File: rtl/switch_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : switch_conditioner
// Brief    : Synchronises and debounces 8 slide switches. Also registers the
//            change strobe, the population count and the pattern mode.
// Revision : 1.0 - initial release
// ============================================================================
module switch_conditioner #(
    parameter int DEBOUNCE_COUNT = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] switchIn,
    output logic [7:0] switchOut,
    output logic       changed,
    output logic [3:0] popCount,
    output logic [1:0] mode
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_COUNT - 1);

    logic [7:0] r_sync1;
    logic [7:0] r_sync2;
    logic [7:0] r_out;
    logic       r_changed;
    logic [3:0] r_pop;

    logic [7:0] w_flip;
    logic [7:0] w_next;
    logic [3:0] w_pop;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi = gi + 1) begin : g_bit
            logic [CNT_W-1:0] r_cnt;
            logic             w_diff;
            logic             w_last;

            assign w_diff     = r_sync2[gi] ^ r_out[gi];
            assign w_last     = (r_cnt == C_LAST);
            assign w_flip[gi] = w_diff & w_last;

            // Any sample agreeing with the debounced value restarts the count
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (!w_diff || w_last) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    endgenerate

    assign w_next = r_out ^ w_flip;

    // Count is taken from the next vector so it lands on the same edge
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < 8; i++) begin
            w_pop = w_pop + 4'(w_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_out     <= '0;
            r_changed <= 1'b0;
            r_pop     <= '0;
        end else begin
            r_sync1   <= switchIn;
            r_sync2   <= r_sync1;
            r_out     <= w_next;
            r_changed <= |w_flip;
            r_pop     <= w_pop;
        end
    end

    assign switchOut = r_out;
    assign changed   = r_changed;
    assign popCount  = r_pop;
    assign mode      = r_pop[1:0];

endmodule
`default_nettype wire

// File: tb/tb_switch_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_conditioner
// Brief    : Directed cycle-exact bench for switch_conditioner with
//            DEBOUNCE_COUNT=4 (a level change shows on its 6th sampling edge).
// Revision : 1.0 - initial release
// ============================================================================
module tb_switch_conditioner;

    localparam int C_DEB = 4;

    logic       clk;
    logic       rst;
    logic [7:0] switchIn;
    logic [7:0] switchOut;
    logic       changed;
    logic [3:0] popCount;
    logic [1:0] mode;

    int checks;
    int failures;

    typedef struct {
        logic       rst;
        logic [7:0] sw;
        logic [7:0] out;
        logic       ch;
    } vec_t;

    vec_t vecs[$];

    switch_conditioner #(
        .DEBOUNCE_COUNT(C_DEB),
        .CNT_W         (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .switchIn (switchIn),
        .switchOut(switchOut),
        .changed  (changed),
        .popCount (popCount),
        .mode     (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [7:0] sw, input logic [7:0] out, input logic ch);
        vec_t v;
        v.rst = r;
        v.sw  = sw;
        v.out = out;
        v.ch  = ch;
        vecs.push_back(v);
    endtask

    // Steady input 'sw' from a settled state 'old': 5 quiet edges, flip, quiet
    task automatic add_flip(input logic [7:0] sw, input logic [7:0] old);
        for (int i = 0; i < 5; i++) add(1'b0, sw, old, 1'b0);
        add(1'b0, sw, sw, 1'b1);
        add(1'b0, sw, sw, 1'b0);
    endtask

    task automatic step_chk(input string name, input logic r, input logic [7:0] sw,
                            input logic [7:0] exp_out, input logic exp_ch);
        logic [3:0] exp_pop;
        rst      = r;
        switchIn = sw;
        @(posedge clk);
        #1;
        exp_pop = 4'($countones(exp_out));
        checks++;
        if (switchOut !== exp_out) begin
            failures++;
            $display("FAIL %s switchOut got=%h exp=%h", name, switchOut, exp_out);
        end
        checks++;
        if (changed !== exp_ch) begin
            failures++;
            $display("FAIL %s changed got=%b exp=%b", name, changed, exp_ch);
        end
        checks++;
        if (popCount !== exp_pop) begin
            failures++;
            $display("FAIL %s popCount got=%0d exp=%0d", name, popCount, exp_pop);
        end
        checks++;
        if (mode !== exp_pop[1:0]) begin
            failures++;
            $display("FAIL %s mode got=%0d exp=%0d", name, mode, exp_pop[1:0]);
        end
    endtask

    task automatic run_flip(input string name, input logic [7:0] sw, input logic [7:0] old);
        for (int i = 0; i < 5; i++) step_chk(name, 1'b0, sw, old, 1'b0);
        step_chk(name, 1'b0, sw, sw, 1'b1);
        step_chk(name, 1'b0, sw, sw, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        switchIn = 8'hFF;

        // Reset with all switches up, release, then a set of level changes
        for (int i = 0; i < 3; i++) add(1'b1, 8'hFF, 8'h00, 1'b0);
        add_flip(8'hFF, 8'h00);
        add_flip(8'h00, 8'hFF);
        add_flip(8'h01, 8'h00);
        add_flip(8'h00, 8'h01);
        add_flip(8'h07, 8'h00);
        add_flip(8'h00, 8'h07);
        add_flip(8'hA5, 8'h00);
        add_flip(8'h00, 8'hA5);

        foreach (vecs[i]) begin
            step_chk($sformatf("vec%0d", i), vecs[i].rst, vecs[i].sw, vecs[i].out, vecs[i].ch);
        end

        // Glitch: bit3 high 3 cycles, low 1, then high; flip 6 edges after final rise
        for (int i = 0; i < 3; i++) step_chk("glitch_hi", 1'b0, 8'h08, 8'h00, 1'b0);
        step_chk("glitch_lo", 1'b0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) step_chk("glitch_wait", 1'b0, 8'h08, 8'h00, 1'b0);
        step_chk("glitch_flip", 1'b0, 8'h08, 8'h08, 1'b1);
        step_chk("glitch_hold", 1'b0, 8'h08, 8'h08, 1'b0);
        run_flip("glitch_clr", 8'h00, 8'h08);

        // Reset mid-count: two counting edges then one reset edge
        for (int i = 0; i < 4; i++) step_chk("midrst_cnt", 1'b0, 8'h80, 8'h00, 1'b0);
        step_chk("midrst_rst", 1'b1, 8'h80, 8'h00, 1'b0);
        run_flip("midrst_rel", 8'h80, 8'h00);
        run_flip("midrst_clr", 8'h00, 8'h80);

        // Staggered bits on consecutive edges keep changed high for two cycles
        step_chk("stag_b0", 1'b0, 8'h01, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) step_chk("stag_wait", 1'b0, 8'h03, 8'h00, 1'b0);
        step_chk("stag_f0", 1'b0, 8'h03, 8'h01, 1'b1);
        step_chk("stag_f1", 1'b0, 8'h03, 8'h03, 1'b1);
        step_chk("stag_hold", 1'b0, 8'h03, 8'h03, 1'b0);
        run_flip("stag_clr", 8'h00, 8'h03);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/switch_conditioner.md
Name: switch_conditioner

Overview:
Upstream front-end for the LED pattern generator. It takes the 8 raw board slide switches, synchronises each bit into the clk domain, and debounces each bit independently. It outputs a clean 8-bit switch vector, a one-cycle change strobe, the population count, and the 2-bit pattern mode (popcount mod 4). The pattern block consumes these directly instead of sampling raw switches.

Parameters:
DEBOUNCE_COUNT, 1000000, consecutive cycles a synchronised bit must differ from its debounced value before the debounced value flips (20 ms at 50 MHz); legal range 2..2^CNT_W.
CNT_W, 20, width of each per-bit debounce counter.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
switchIn  input  8  raw asynchronous switch levels.
switchOut  output  8  debounced switch vector (registered).
changed  output  1  one-cycle pulse: at least one switchOut bit flipped on this edge.
popCount  output  4  number of 1s in switchOut (0..8), registered, same edge as switchOut.
mode  output  2  popCount[1:0] (popCount mod 4); 0/1/2/3 select the pattern block's fill, left-rotate, right-rotate and bounce modes.

Behaviour:
- Reset on a clk edge with rst=1: sync stages, all counters, switchOut, changed, popCount and mode all go to 0. rst has priority over every other event, including a debounce flip due on the same edge.
- Synchroniser: for each bit, s1 <= switchIn[i], s2 <= s1. Only s2 feeds the debouncer. No other logic samples switchIn.
- Per-bit debouncer, evaluated each edge with rst=0:
  - s2 == switchOut[i]: counter <= 0.
  - s2 != switchOut[i] and counter < DEBOUNCE_COUNT-1: counter <= counter+1.
  - s2 != switchOut[i] and counter == DEBOUNCE_COUNT-1: switchOut[i] <= s2, counter <= 0.
- Latency:
  - The raw level must be stable before edge k. switchOut then reflects it at edge k+1+DEBOUNCE_COUNT, i.e. DEBOUNCE_COUNT+2 edges after the first sampling edge.
  - Any single-cycle return of s2 to the old value restarts the full count.
- Bits are fully independent. Several bits may flip on the same edge; changed pulses once for that edge.
- changed: registered. It is 1 for exactly the cycle following an edge on which any bit flipped, and 0 otherwise. Back-to-back flips on consecutive edges keep it high on both cycles.
- popCount and mode:
  - Computed from the next value of switchOut and registered on the same edge, so they are always consistent with switchOut. No extra cycle of lag.
  - Width rule: popCount is an unsigned 4-bit sum of eight 1-bit terms; it cannot overflow (max 8 = 4'b1000, mode 0).
- Counters saturate logically at DEBOUNCE_COUNT-1 via the flip rule and never wrap.
- Reset mid-count discards the partial count. After reset deassertion, any switch held at 1 re-debounces from 0 and produces a normal change pulse.

Test Plan:
1. With DEBOUNCE_COUNT=4, hold rst=1 for 3 edges with switchIn=8'hFF -> switchOut=0, changed=0, popCount=0, mode=0. Release rst -> switchOut=8'hFF exactly 6 edges after the first post-reset edge; changed=1 for one cycle; popCount=8; mode=0.
2. From switchOut=8'h00, set switchIn=8'h01 -> switchOut=8'h01 at edge +6; changed pulses once; popCount=1; mode=1. Clear back to 8'h00 -> switchOut returns to 8'h00 after another 6 edges; changed pulses again.
3. Glitch rejection: drive switchIn[3] high for 3 cycles, low for 1 cycle, then high steadily -> no change until 6 edges after the final rise; earlier pulses never alter switchOut or changed.
4. Simultaneous bits: switch 8'h00 -> 8'h07 in one cycle -> all three bits flip on the same edge; changed high for exactly one cycle; popCount=3; mode=3.
5. Reset mid-count: switchIn=8'h80, assert rst for 1 edge after 2 debounce cycles -> everything returns to 0. After release, switchOut=8'h80 takes the full 6 edges; popCount=1; mode=1.
6. Staggered bits: raise bit0, then raise bit1 one cycle later -> switchOut shows 8'h01 then 8'h03 on consecutive edges; changed high for 2 consecutive cycles; popCount goes 1 then 2; mode goes 1 then 2.
